// File: rtl/exe_mdu_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
interface exe_mdu_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned FRWD_N = 2
);
    localparam int unsigned SELW = $clog2(FRWD_N + 1);

    logic                     flush;
    logic                     in_valid;
    logic                     in_ready;
    logic [2:0]               op;
    logic [XLEN-1:0]          rs1_data;
    logic [XLEN-1:0]          rs2_data;
    logic [FRWD_N*XLEN-1:0]   frwd_data;
    logic [SELW-1:0]          frwd_sel_a;
    logic [SELW-1:0]          frwd_sel_b;
    logic                     out_valid;
    logic                     out_ready;
    logic [XLEN-1:0]          out_result;
    logic                     busy;

    modport master (
        output flush, in_valid, op, rs1_data, rs2_data, frwd_data, frwd_sel_a, frwd_sel_b,
               out_ready,
        input  in_ready, out_valid, out_result, busy
    );

    modport slave (
        input  flush, in_valid, op, rs1_data, rs2_data, frwd_data, frwd_sel_a, frwd_sel_b,
               out_ready,
        output in_ready, out_valid, out_result, busy
    );
endinterface

// File: rtl/exe_mdu.sv
// RV32M multi-cycle multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Define MDU_FAST_MUL_EN to compute all multiplies in one cycle with a combinational multiplier.
module exe_mdu #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned FRWD_N = 2
) (
    input logic         CLK,
    input logic         RSTn,
    exe_mdu_if.slave    mdu
);
    localparam int unsigned SELW = $clog2(FRWD_N + 1);
    localparam int unsigned CNTW = $clog2(XLEN);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              sa_q, sa_d, sb_q, sb_d;
    logic [XLEN:0]     hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d, b_q, b_d, res_q, res_d;

    logic [XLEN-1:0]   a_mux, b_mux, a_abs, b_abs, special_res;
    logic              a_is_s, b_is_s, a_sgn, b_sgn, is_div, div_zero, div_ovf;

    always_comb begin
        a_mux = mdu.rs1_data;
        b_mux = mdu.rs2_data;
        for (int i = 0; i < int'(FRWD_N); i++) begin
            if (mdu.frwd_sel_a == SELW'(i + 1)) a_mux = mdu.frwd_data[i*XLEN +: XLEN];
            if (mdu.frwd_sel_b == SELW'(i + 1)) b_mux = mdu.frwd_data[i*XLEN +: XLEN];
        end
    end

    always_comb begin
        is_div   = mdu.op[2];
        a_is_s   = (mdu.op == 3'd1) || (mdu.op == 3'd2) || (mdu.op == 3'd4) || (mdu.op == 3'd6);
        b_is_s   = (mdu.op == 3'd1) || (mdu.op == 3'd4) || (mdu.op == 3'd6);
        a_sgn    = a_is_s & a_mux[XLEN-1];
        b_sgn    = b_is_s & b_mux[XLEN-1];
        a_abs    = a_sgn ? -a_mux : a_mux;
        b_abs    = b_sgn ? -b_mux : b_mux;
        div_zero = is_div && (b_mux == '0);
        div_ovf  = is_div && !mdu.op[0] && (a_mux == {1'b1, {(XLEN-1){1'b0}}}) && (b_mux == '1);
        // op[1] separates REM/REMU from DIV/DIVU
        if (div_zero) special_res = mdu.op[1] ? a_mux : '1;
        else          special_res = mdu.op[1] ? '0 : a_mux;
    end

`ifdef MDU_FAST_MUL_EN
    logic signed [XLEN:0]       fa, fb;
    logic signed [2*XLEN+1:0]   fp;
    logic [XLEN-1:0]            fast_res;

    always_comb begin
        fa       = $signed({a_sgn, a_mux});
        fb       = $signed({b_sgn, b_mux});
        fp       = fa * fb;
        fast_res = (mdu.op == 3'd0) ? fp[XLEN-1:0] : fp[2*XLEN-1:XLEN];
    end
`endif

    logic [XLEN:0]     mul_sum, div_shift, step_hi;
    logic [XLEN-1:0]   step_lo, quot, rem, mul_res, div_res;
    logic [2*XLEN-1:0] prod, prod_s;
    logic              qbit;

    always_comb begin
        mul_sum   = hi_q + (lo_q[0] ? {1'b0, b_q} : '0);
        div_shift = {hi_q[XLEN-1:0], lo_q[XLEN-1]};
        qbit      = (div_shift >= {1'b0, b_q});
        if (op_q[2]) begin
            step_hi = qbit ? (div_shift - {1'b0, b_q}) : div_shift;
            step_lo = {lo_q[XLEN-2:0], qbit};
        end else begin
            step_hi = {1'b0, mul_sum[XLEN:1]};
            step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        // Magnitudes were iterated; apply signs only on the final step
        prod    = {step_hi[XLEN-1:0], step_lo};
        prod_s  = (sa_q ^ sb_q) ? -prod : prod;
        mul_res = (op_q == 3'd0) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        quot    = (sa_q ^ sb_q) ? -step_lo : step_lo;
        rem     = sa_q ? -step_hi[XLEN-1:0] : step_hi[XLEN-1:0];
        div_res = op_q[1] ? rem : quot;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        b_d     = b_q;
        res_d   = res_q;
        if (mdu.flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (mdu.in_valid) begin
                        op_d  = mdu.op;
                        sa_d  = a_sgn;
                        sb_d  = b_sgn;
                        hi_d  = '0;
                        lo_d  = a_abs;
                        b_d   = b_abs;
                        cnt_d = CNTW'(XLEN - 1);
                        if (div_zero || div_ovf) begin
                            res_d   = special_res;
                            state_d = StDone;
`ifdef MDU_FAST_MUL_EN
                        end else if (!is_div) begin
                            res_d   = fast_res;
                            state_d = StDone;
`endif
                        end else begin
                            state_d = StCalc;
                        end
                    end
                end
                StCalc: begin
                    hi_d = step_hi;
                    lo_d = step_lo;
                    if (cnt_q == '0) begin
                        res_d   = op_q[2] ? div_res : mul_res;
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                StDone: begin
                    if (mdu.out_ready) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    assign mdu.in_ready   = (state_q == StIdle);
    assign mdu.out_valid  = (state_q == StDone);
    assign mdu.out_result = res_q;
    assign mdu.busy       = (mdu.in_valid & (state_q != StIdle)) | (state_q == StCalc);
endmodule
